// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - request indices, default stall/flush mask sets and FSM state type for the hazard arbiter
package hazard_pkg;

    localparam int HAZ_NSTAGE = 6;
    localparam int HAZ_NREQ   = 8;

    // Request indices; a higher index wins arbitration
    localparam int HAZ_REQ_COMPRESS   = 0;
    localparam int HAZ_REQ_LOAD_USE   = 1;
    localparam int HAZ_REQ_MUL_DIV    = 2;
    localparam int HAZ_REQ_JUMP       = 3;
    localparam int HAZ_REQ_TRAP_STALL = 4;
    localparam int HAZ_REQ_TRAP_FLUSH = 5;
    localparam int HAZ_REQ_RAM_IF     = 6;
    localparam int HAZ_REQ_RAM_MEM    = 7;

    // Stage bits: 0=PC 1=Pre_IF 2=IF_ID 3=ID_EX 4=EX_MEM 5=MEM_WB.
    // Slice k (bits [k*6 +: 6]) belongs to request k, so index 7 is leftmost.
    localparam logic [HAZ_NREQ*HAZ_NSTAGE-1:0] HAZ_STALL_MASKS = {
        6'h1D, 6'h01, 6'h02, 6'h3F, 6'h02, 6'h07, 6'h07, 6'h02
    };
    localparam logic [HAZ_NREQ*HAZ_NSTAGE-1:0] HAZ_FLUSH_MASKS = {
        6'h20, 6'h00, 6'h0E, 6'h0E, 6'h0E, 6'h10, 6'h08, 6'h02
    };

    // Pulse-type redirects (jump, trap_flush) must survive losing to a memory stall
    localparam logic [HAZ_NREQ-1:0] HAZ_DEFER_MASK =
        (8'(1) << HAZ_REQ_JUMP) | (8'(1) << HAZ_REQ_TRAP_FLUSH);

    typedef enum logic {
        HAZ_ST_RST_FLUSH = 1'b0,
        HAZ_ST_RUN       = 1'b1
    } haz_state_e;

endpackage

// File: rtl/hazard_prio_enc.sv
// rtl/hazard_prio_enc.sv - highest-set-bit encoder producing a valid flag and the winning index
module hazard_prio_enc #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    output logic          o_vld,
    output logic [IW-1:0] o_idx
);

    // Ascending scan so the last (highest) set bit overrides lower ones
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (i_req[k]) begin
                o_vld = 1'b1;
                o_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - prioritised stall/flush arbiter with reset flush, deferral and watchdog; optional win counters under HAZARD_PERF_EN
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int                         NSTAGE           = HAZ_NSTAGE,
    parameter int                         NREQ             = HAZ_NREQ,
    parameter logic [NREQ*NSTAGE-1:0]     STALL_MASKS      = HAZ_STALL_MASKS,
    parameter logic [NREQ*NSTAGE-1:0]     FLUSH_MASKS      = HAZ_FLUSH_MASKS,
    parameter logic [NREQ-1:0]            DEFER_MASK       = HAZ_DEFER_MASK,
    parameter int                         RST_FLUSH_CYCLES = 2,
    parameter int                         WDOG_LIMIT       = 1024,
    localparam int                        IW               = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic              winner_vld_o,
    output logic [IW-1:0]     winner_o,
    output logic [NREQ-1:0]   pending_o,
`ifdef HAZARD_PERF_EN
    input  logic [IW-1:0]     perf_sel_i,
    output logic [31:0]       perf_cnt_o,
`endif
    output logic              wdog_o
);

    localparam int RCW = $clog2(RST_FLUSH_CYCLES + 1);
    localparam int WCW = $clog2(WDOG_LIMIT + 1);

    haz_state_e      r_state;
    haz_state_e      w_state_nxt;
    logic [RCW-1:0]  r_rst_cnt;
    logic [NREQ-1:0] r_pending;
    logic [WCW-1:0]  r_wdog_cnt;
    logic            r_wdog;

    logic [NREQ-1:0] w_eff;
    logic            w_win_vld;
    logic [IW-1:0]   w_win_idx;
    logic [NREQ-1:0] w_win_onehot;
    logic            w_run;
    logic            w_run_stall;

    assign w_eff       = req_i | r_pending;
    assign w_run       = (r_state == HAZ_ST_RUN);
    assign w_run_stall = w_run && (|stall_o);
    assign pending_o   = r_pending;
    assign wdog_o      = r_wdog;

    hazard_prio_enc #(
        .N  (NREQ),
        .IW (IW)
    ) u_prio_enc (
        .i_req (w_eff),
        .o_vld (w_win_vld),
        .o_idx (w_win_idx)
    );

    // One-hot of the winner, used to retire its pending bit
    always_comb begin
        w_win_onehot = '0;
        if (w_win_vld) begin
            w_win_onehot[w_win_idx] = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HAZ_ST_RST_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave the flush phase once enough post-reset edges have passed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HAZ_ST_RST_FLUSH: begin
                if (r_rst_cnt == RCW'(RST_FLUSH_CYCLES - 1)) begin
                    w_state_nxt = HAZ_ST_RUN;
                end
            end
            default: w_state_nxt = HAZ_ST_RUN;
        endcase
    end

    // FSM outputs: full flush during the reset phase, winner's mask slices while running
    always_comb begin
        stall_o      = '0;
        flush_o      = '0;
        winner_vld_o = 1'b0;
        winner_o     = '0;
        case (r_state)
            HAZ_ST_RST_FLUSH: begin
                flush_o = '1;
            end
            default: begin
                if (w_win_vld) begin
                    stall_o      = STALL_MASKS[int'(w_win_idx)*NSTAGE +: NSTAGE];
                    flush_o      = FLUSH_MASKS[int'(w_win_idx)*NSTAGE +: NSTAGE];
                    winner_vld_o = 1'b1;
                    winner_o     = w_win_idx;
                end
            end
        endcase
    end

    // Counts edges spent in the reset flush phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_cnt <= '0;
        end else if (!w_run) begin
            r_rst_cnt <= r_rst_cnt + RCW'(1);
        end
    end

    // Deferral: losers in DEFER_MASK are held; the winner's bit clears (clear beats set)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (w_run) begin
            r_pending <= DEFER_MASK & w_eff & ~w_win_onehot;
        end
    end

    // Watchdog: saturating run of consecutive stall cycles, sticky flag at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
            r_wdog     <= 1'b0;
        end else if (w_run_stall) begin
            if (r_wdog_cnt != WCW'(WDOG_LIMIT)) begin
                r_wdog_cnt <= r_wdog_cnt + WCW'(1);
            end
            if (r_wdog_cnt == WCW'(WDOG_LIMIT - 1)) begin
                r_wdog <= 1'b1;
            end
        end else begin
            r_wdog_cnt <= '0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_cnt [NREQ];

    // Per-request win counters, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                r_perf_cnt[k] <= '0;
            end
        end else if (w_run && w_win_vld) begin
            r_perf_cnt[w_win_idx] <= r_perf_cnt[w_win_idx] + 32'd1;
        end
    end

    // Counter readback; selects beyond the request count read as zero
    always_comb begin
        perf_cnt_o = '0;
        if (int'(perf_sel_i) < NREQ) begin
            perf_cnt_o = r_perf_cnt[perf_sel_i];
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_i;
    logic [5:0] stall_o;
    logic [5:0] flush_o;
    logic       winner_vld_o;
    logic [2:0] winner_o;
    logic [7:0] pending_o;
    logic       wdog_o;
`ifdef HAZARD_PERF_EN
    logic [2:0]  perf_sel_i;
    logic [31:0] perf_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    pipeline_hazard_ctrl #(
        .WDOG_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .winner_vld_o (winner_vld_o),
        .winner_o     (winner_o),
        .pending_o    (pending_o),
`ifdef HAZARD_PERF_EN
        .perf_sel_i   (perf_sel_i),
        .perf_cnt_o   (perf_cnt_o),
`endif
        .wdog_o       (wdog_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Outputs packed as {stall, flush, vld, winner}
    function automatic logic [15:0] outs(input logic [5:0] s, input logic [5:0] f,
                                         input logic v, input logic [2:0] w);
        return {s, f, v, w};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req_i = 8'h00;
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_i = 8'hFF;
        #1;
        total++;
        if ({stall_o, flush_o, winner_vld_o, winner_o, pending_o, wdog_o} !== {6'h00, 6'h3F, 1'b0, 3'd0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals got s=%h f=%h v=%b w=%0d p=%h wd=%b want s=00 f=3f v=0 w=0 p=00 wd=0",
                     stall_o, flush_o, winner_vld_o, winner_o, pending_o, wdog_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({stall_o, flush_o, winner_vld_o} !== {6'h00, 6'h3F, 1'b0}) begin
                bad++;
                $display("FAIL rst_flush_cycle%0d got s=%h f=%h v=%b want s=00 f=3f v=0",
                         i, stall_o, flush_o, winner_vld_o);
            end
        end
        @(negedge clk);
        total++;
        if (outs(stall_o, flush_o, winner_vld_o, winner_o) !== outs(6'h1D, 6'h20, 1'b1, 3'd7)) begin
            bad++;
            $display("FAIL first_run got s=%h f=%h v=%b w=%0d want s=1d f=20 v=1 w=7",
                     stall_o, flush_o, winner_vld_o, winner_o);
        end
        total++;
        if (pending_o !== 8'h00) begin
            bad++;
            $display("FAIL first_run_pending got %h want 00", pending_o);
        end
    endtask

    task automatic test_single_defer();
        apply_reset();
        req_i = 8'h88;
        @(negedge clk);
        total++;
        if (outs(stall_o, flush_o, winner_vld_o, winner_o) !== outs(6'h1D, 6'h20, 1'b1, 3'd7)) begin
            bad++;
            $display("FAIL d88_c0 got s=%h f=%h v=%b w=%0d want s=1d f=20 v=1 w=7",
                     stall_o, flush_o, winner_vld_o, winner_o);
        end
        @(posedge clk); #1;
        total++;
        if (pending_o !== 8'h08) begin
            bad++;
            $display("FAIL d88_pending got %h want 08", pending_o);
        end
        req_i = 8'h00;
        @(negedge clk);
        total++;
        if (outs(stall_o, flush_o, winner_vld_o, winner_o) !== outs(6'h02, 6'h0E, 1'b1, 3'd3)) begin
            bad++;
            $display("FAIL d88_c1 got s=%h f=%h v=%b w=%0d want s=02 f=0e v=1 w=3",
                     stall_o, flush_o, winner_vld_o, winner_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({outs(stall_o, flush_o, winner_vld_o, winner_o), pending_o} !== {outs(6'h00, 6'h00, 1'b0, 3'd0), 8'h00}) begin
            bad++;
            $display("FAIL d88_c2 got s=%h f=%h v=%b w=%0d p=%h want all 0",
                     stall_o, flush_o, winner_vld_o, winner_o, pending_o);
        end
    endtask

    task automatic test_two_defer();
        apply_reset();
        req_i = 8'hA8;
        @(posedge clk); #1;
        total++;
        if (pending_o !== 8'h28) begin
            bad++;
            $display("FAIL a8_pending got %h want 28", pending_o);
        end
        req_i = 8'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({winner_o, stall_o, pending_o} !== {3'd7, 6'h1D, 8'h28}) begin
                bad++;
                $display("FAIL a8_hold%0d got w=%0d s=%h p=%h want w=7 s=1d p=28",
                         i, winner_o, stall_o, pending_o);
            end
            @(posedge clk); #1;
        end
        req_i = 8'h00;
        @(negedge clk);
        total++;
        if (outs(stall_o, flush_o, winner_vld_o, winner_o) !== outs(6'h02, 6'h0E, 1'b1, 3'd5)) begin
            bad++;
            $display("FAIL a8_trap got s=%h f=%h v=%b w=%0d want s=02 f=0e v=1 w=5",
                     stall_o, flush_o, winner_vld_o, winner_o);
        end
        @(posedge clk); #1;
        total++;
        if (pending_o !== 8'h08) begin
            bad++;
            $display("FAIL a8_pending2 got %h want 08", pending_o);
        end
        @(negedge clk);
        total++;
        if (outs(stall_o, flush_o, winner_vld_o, winner_o) !== outs(6'h02, 6'h0E, 1'b1, 3'd3)) begin
            bad++;
            $display("FAIL a8_jump got s=%h f=%h v=%b w=%0d want s=02 f=0e v=1 w=3",
                     stall_o, flush_o, winner_vld_o, winner_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({winner_vld_o, pending_o} !== {1'b0, 8'h00}) begin
            bad++;
            $display("FAIL a8_idle got v=%b p=%h want v=0 p=00", winner_vld_o, pending_o);
        end
    endtask

    task automatic test_no_defer();
        apply_reset();
        req_i = 8'h06;
        @(negedge clk);
        total++;
        if (outs(stall_o, flush_o, winner_vld_o, winner_o) !== outs(6'h07, 6'h10, 1'b1, 3'd2)) begin
            bad++;
            $display("FAIL n06 got s=%h f=%h v=%b w=%0d want s=07 f=10 v=1 w=2",
                     stall_o, flush_o, winner_vld_o, winner_o);
        end
        @(posedge clk); #1;
        req_i = 8'h00;
        total++;
        if (pending_o !== 8'h00) begin
            bad++;
            $display("FAIL n06_pending got %h want 00", pending_o);
        end
        @(negedge clk);
        total++;
        if (winner_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL n06_idle got v=%b want 0", winner_vld_o);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req_i = 8'h88;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({winner_o, pending_o} !== {3'd7, 8'h08}) begin
            bad++;
            $display("FAIL held_c1 got w=%0d p=%h want w=7 p=08", winner_o, pending_o);
        end
        @(posedge clk); #1;
        req_i = 8'h08;
        @(negedge clk);
        total++;
        if (outs(stall_o, flush_o, winner_vld_o, winner_o) !== outs(6'h02, 6'h0E, 1'b1, 3'd3)) begin
            bad++;
            $display("FAIL held_same got s=%h f=%h v=%b w=%0d want s=02 f=0e v=1 w=3",
                     stall_o, flush_o, winner_vld_o, winner_o);
        end
        @(posedge clk); #1;
        req_i = 8'h00;
        total++;
        if (pending_o !== 8'h00) begin
            bad++;
            $display("FAIL held_nodup got p=%h want 00", pending_o);
        end
        @(negedge clk);
        total++;
        if (winner_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL held_idle got v=%b want 0", winner_vld_o);
        end
    endtask

    task automatic test_wdog();
        apply_reset();
        req_i = 8'h02;
        repeat (4) @(posedge clk);
        #1;
        req_i = 8'h00;
        @(posedge clk); #1;
        req_i = 8'h02;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            total++;
            if (wdog_o !== 1'b0) begin
                bad++;
                $display("FAIL wdog_early%0d got %b want 0", i, wdog_o);
            end
        end
        @(posedge clk); #1;
        total++;
        if (wdog_o !== 1'b1) begin
            bad++;
            $display("FAIL wdog_fire got %b want 1", wdog_o);
        end
        req_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wdog_o !== 1'b1) begin
            bad++;
            $display("FAIL wdog_sticky got %b want 1", wdog_o);
        end
    endtask

    task automatic test_async_reset();
        req_i = 8'hA8;
        @(posedge clk); #1;
        total++;
        if (pending_o !== 8'h28) begin
            bad++;
            $display("FAIL areset_setup got p=%h want 28", pending_o);
        end
        req_i = 8'h80;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({pending_o, wdog_o, stall_o, flush_o, winner_vld_o, winner_o} !==
            {8'h00, 1'b0, 6'h00, 6'h3F, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL areset got p=%h wd=%b s=%h f=%h v=%b w=%0d want p=00 wd=0 s=00 f=3f v=0 w=0",
                     pending_o, wdog_o, stall_o, flush_o, winner_vld_o, winner_o);
        end
        rst_n = 1'b1;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        apply_reset();
        perf_sel_i = 3'd1;
        req_i = 8'h02;
        repeat (5) @(posedge clk);
        #1;
        req_i = 8'h00;
        total++;
        if (perf_cnt_o !== 32'd5) begin
            bad++;
            $display("FAIL perf_cnt got %0d want 5", perf_cnt_o);
        end
        req_i = 8'h88;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({perf_cnt_o, pending_o} !== {32'd0, 8'h00}) begin
            bad++;
            $display("FAIL perf_reset got c=%0d p=%h want c=0 p=00", perf_cnt_o, pending_o);
        end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req_i = 8'h00;
`ifdef HAZARD_PERF_EN
        perf_sel_i = 3'd0;
`endif
        test_reset();
        test_single_defer();
        test_two_defer();
        test_no_defer();
        test_back_to_back();
        test_wdog();
        test_async_reset();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard arbiter for the in-order pipeline. It resolves NREQ prioritised stall/flush requests into per-stage stall_o/flush_o vectors over NSTAGE stages, with the highest request index winning. Sequential state adds three behaviours:

- a timed post-reset flush sequence;
- a deferral register so pulse-type redirects (branch, trap flush) are not lost while a higher-priority memory stall is active;
- a stall watchdog.

It sits between the hazard sources (IF/MEM RAM, ID load-use, EX branch/mul-div, WB trap) and the pipeline registers.

## Interface
Parameters:
- NSTAGE, 6, number of stage control bits; bit0=PC, 1=Pre_IF, 2=IF_ID, 3=ID_EX, 4=EX_MEM, 5=MEM_WB
- NREQ, 8, number of request inputs; a higher index means higher priority
- STALL_MASKS, HAZ_STALL_MASKS (package), NREQ×NSTAGE packed, slice k = stall vector of request k
- FLUSH_MASKS, HAZ_FLUSH_MASKS (package), NREQ×NSTAGE packed, slice k = flush vector of request k
- DEFER_MASK, 8'h28, requests latched as pending when they lose arbitration
- RST_FLUSH_CYCLES, 2, cycles of full flush after reset release (≥1)
- WDOG_LIMIT, 1024, consecutive stall cycles before the watchdog fires

Ports (clock and reset first):
- clk  in  1  clock; all state on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_i  in  NREQ  raw requests; default map 0=compress, 1=load_use, 2=mul_div, 3=jump, 4=trap_stall, 5=trap_flush, 6=ram_if, 7=ram_mem
- stall_o  out  NSTAGE  per-stage stall
- flush_o  out  NSTAGE  per-stage flush
- winner_vld_o  out  1  an effective request won this cycle
- winner_o  out  IW  index of the winning request; IW=max(1,$clog2(NREQ))
- pending_o  out  NREQ  deferred requests awaiting issue
- wdog_o  out  1  sticky watchdog flag

## Operation
- The effective request vector is eff = req_i | pending.
- The winner is the highest set index of eff.
- While in RUN:
  - stall_o and flush_o are the winner's mask slices.
  - With no winner, both are 0, winner_vld_o=0 and winner_o=0.
- Deferral:
  - For each k in DEFER_MASK, pending[k] sets when eff[k]=1 and k is not the winner.
  - pending[k] clears when k wins.
  - Set and clear are evaluated on the same edge; clear takes precedence.
  - Bits outside DEFER_MASK never set.
- FSM states RST_FLUSH and RUN:
  - Reset enters RST_FLUSH.
  - RST_FLUSH drives stall_o=0, flush_o=all ones and winner_vld_o=0; requests are ignored and pending is not updated.
  - RST_FLUSH moves to RUN after RST_FLUSH_CYCLES edges with rst_n high.
- Watchdog:
  - A counter increments on each RUN cycle with |stall_o=1 and clears on a cycle with stall_o=0.
  - At count = WDOG_LIMIT, wdog_o sets and stays set until reset.
  - The counter saturates at WDOG_LIMIT.
- Reset values: state=RST_FLUSH, pending=0, watchdog count=0, wdog_o=0. While rst_n=0: stall_o=0, flush_o=all ones, winner_vld_o=0, winner_o=0, pending_o=0.
- Reset asserted mid-stall or while a deferral is pending drops all state immediately (asynchronous).

## Timing
- stall_o, flush_o, winner_vld_o and winner_o are combinational from req_i and registered state: zero-cycle latency from a request.
- pending_o is registered. A deferred request is issued on the first cycle in which no higher-index request is active, at the earliest one cycle after the cycle in which it lost.
- A request that is held high and a pending bit for the same index give identical outputs; the request is issued once per win and is not duplicated.
- Two deferred requests resolve in index order on consecutive free cycles.
- wdog_o rises on the edge on which the count reaches WDOG_LIMIT.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds NREQ 32-bit win counters; counter k increments on every RUN cycle in which k wins, wrapping at 2^32.
  - Adds ports perf_sel_i (in, IW) and perf_cnt_o (out, 32); perf_cnt_o = counter[perf_sel_i], combinational.
  - Counters reset to 0.
  - A perf_sel_i value ≥ NREQ reads 0.
- HAZARD_PERF_EN undefined: no counters and no perf ports; all other behaviour is identical.

## Structure
- Package hazard_pkg holds:
  - the request index constants (HAZ_REQ_COMPRESS … HAZ_REQ_RAM_MEM);
  - the default mask sets:
    - stall 02,07,07,02,3F,02,01,1D;
    - flush 02,08,10,0E,0E,0E,00,20 (hex, index 0..7);
  - the FSM state enum.
- One sub-module, hazard_prio_enc: a parametrised highest-set-bit encoder producing the valid flag and index.

## Test plan
- Reset release with req_i=8'hFF: flush_o=6'h3F and stall_o=0 for exactly 2 cycles, then stall_o=6'h1D, flush_o=6'h20, winner_o=7.
- req_i=8'h88 for 1 cycle, then 0:
  - cycle 0: stall 1D, flush 20, pending_o=8'h08;
  - cycle 1: stall 02, flush 0E, winner_o=3;
  - cycle 2: all outputs 0.
- req_i=8'hA8 for 1 cycle, then 8'h80 for 3 cycles, then 0: pending_o=8'h28 holds while ram_mem is high, then trap_flush (5) issues first and jump (3) issues on the next cycle.
- req_i=8'h06: winner 2 with stall 07 and flush 10; index 1 is not deferred, so pending_o stays 0.
- WDOG_LIMIT=8, req_i=8'h02 held: wdog_o rises on the 8th stall cycle and stays high after the request drops. A single idle cycle at cycle 5 restarts the count.
- HAZARD_PERF_EN defined: 5 cycles of load_use, then perf_sel_i=1 gives perf_cnt_o=5. Asserting rst_n=0 mid-sequence clears the counters and pending_o asynchronously.
